// File: rtl/alu_writeback_if.sv
// Write-back bus between the ALU result stage and the register-file write port.
// The slave modport is the write-back stage; master is the upstream/regfile side.
interface alu_writeback_if #(
  parameter int WIDTH = 16,
  parameter int DST_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [3:0]       in_sreg;
  logic [2:0]       in_op;
  logic [DST_W-1:0] in_dst;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DST_W-1:0] out_dst;

  modport master (
    output in_valid, in_result, in_sreg, in_op, in_dst, out_ready,
    input  in_ready, out_valid, out_data, out_dst
  );

  modport slave (
    input  in_valid, in_result, in_sreg, in_op, in_dst, out_ready,
    output in_ready, out_valid, out_data, out_dst
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU write-back stage: 2-entry result buffer toward the register file, plus the
// architectural status register {V,C,N,Z} and branch-condition evaluation.
module alu_writeback #(
  parameter int WIDTH = 16,
  parameter int DST_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_writeback_if.slave   wb,
  input  logic             sreg_wr,
  input  logic [3:0]       sreg_din,
  output logic [3:0]       sreg_q,
  input  logic [2:0]       cond_sel,
  output logic             cond_true
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  // Logic ops only define Z and N; arithmetic ops define all four flags.
  function automatic logic [3:0] next_flags(input logic [3:0] cur,
                                            input logic [2:0] op,
                                            input logic [3:0] raw);
    case (op)
      OP_AND, OP_OR:  return {cur[3:2], raw[1:0]};
      OP_ADD, OP_SUB: return raw;
      default:        return cur;
    endcase
  endfunction

  function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] sel);
    case (sel)
      3'b000:  return f[0];
      3'b001:  return ~f[0];
      3'b010:  return f[2];
      3'b011:  return ~f[2];
      3'b100:  return f[1];
      3'b101:  return f[3];
      3'b110:  return f[1] ^ f[3];
      default: return 1'b1;
    endcase
  endfunction

  logic [1:0]       count;
  logic [WIDTH-1:0] head_data_p0;
  logic [DST_W-1:0] head_dst_p0;
  logic [WIDTH-1:0] tail_data_p0;
  logic [DST_W-1:0] tail_dst_p0;
  logic [3:0]       sreg;
  logic             can_push;
  logic             has_data;
  logic             push;
  logic             pop;

  assign can_push = (count != 2'd2);
  assign has_data = (count != 2'd0);
  assign push     = wb.in_valid && can_push;
  assign pop      = has_data && wb.out_ready;

  // Head slot drives the outputs directly; it is left untouched when the last
  // entry pops so out_data/out_dst hold their final value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 2'd0;
      head_data_p0 <= '0;
      head_dst_p0  <= '0;
      tail_data_p0 <= '0;
      tail_dst_p0  <= '0;
      sreg         <= 4'b0000;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data_p0 <= wb.in_result;
            head_dst_p0  <= wb.in_dst;
          end else begin
            tail_data_p0 <= wb.in_result;
            tail_dst_p0  <= wb.in_dst;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_data_p0 <= tail_data_p0;
            head_dst_p0  <= tail_dst_p0;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count=1: the new entry replaces the departing head.
          head_data_p0 <= wb.in_result;
          head_dst_p0  <= wb.in_dst;
        end
        default: ;
      endcase

      if (sreg_wr) begin
        sreg <= sreg_din;
      end else if (push) begin
        sreg <= next_flags(sreg, wb.in_op, wb.in_sreg);
      end
    end
  end

  assign wb.in_ready  = can_push;
  assign wb.out_valid = has_data;
  assign wb.out_data  = head_data_p0;
  assign wb.out_dst   = head_dst_p0;
  assign sreg_q       = sreg;
  assign cond_true    = cond_eval(sreg, cond_sel);

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the buffer and status register.
module tb_alu_writeback;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sreg_wr;
  logic [3:0] sreg_din;
  logic [3:0] sreg_q;
  logic [2:0] cond_sel;
  logic       cond_true;

  alu_writeback_if #(.WIDTH(16), .DST_W(3)) wb ();

  alu_writeback #(.WIDTH(16), .DST_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb),
    .sreg_wr   (sreg_wr),
    .sreg_din  (sreg_din),
    .sreg_q    (sreg_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dst;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  logic [3:0]  m_flags;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] f, input logic [2:0] sel);
    logic v, c, n, z;
    {v, c, n, z} = f;
    case (sel)
      3'd0: return z;        // EQ
      3'd1: return !z;       // NE
      3'd2: return c;        // CS
      3'd3: return !c;       // CC
      3'd4: return n;        // MI
      3'd5: return v;        // VS
      3'd6: return n != v;   // LT
      default: return 1'b1;  // AL
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last.data = '0;
    m_last.dst  = '0;
    m_flags     = 4'b0000;
  endtask

  task automatic check_outputs();
    ent_t head;
    head = (mq.size() != 0) ? mq[0] : m_last;
    chk("out_valid", 32'(wb.out_valid), 32'(mq.size() != 0));
    chk("in_ready",  32'(wb.in_ready),  32'(mq.size() < 2));
    chk("out_data",  32'(wb.out_data),  32'(head.data));
    chk("out_dst",   32'(wb.out_dst),   32'(head.dst));
    chk("sreg_q",    32'(sreg_q),       32'(m_flags));
    chk("cond_true", 32'(cond_true),    32'(cond_ref(m_flags, cond_sel)));
  endtask

  task automatic model_step();
    bit   accept, drain;
    ent_t e;
    accept = wb.in_valid && (mq.size() < 2);
    drain  = (mq.size() > 0) && wb.out_ready;
    if (drain) m_last = mq.pop_front();
    if (accept) begin
      e.data = wb.in_result;
      e.dst  = wb.in_dst;
      mq.push_back(e);
    end
    if (sreg_wr) begin
      m_flags = sreg_din;
    end else if (accept) begin
      if (wb.in_op == 3'd0 || wb.in_op == 3'd1)
        m_flags[1:0] = wb.in_sreg[1:0];
      else if (wb.in_op == 3'd2 || wb.in_op == 3'd6)
        m_flags = wb.in_sreg;
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model, then
  // return just after the next rising edge.
  task automatic cycle(input bit v, input logic [15:0] res, input logic [3:0] sr,
                       input logic [2:0] op, input logic [2:0] dst, input bit ordy,
                       input bit swr, input logic [3:0] sdin, input logic [2:0] csel);
    wb.in_valid  = v;
    wb.in_result = res;
    wb.in_sreg   = sr;
    wb.in_op     = op;
    wb.in_dst    = dst;
    wb.out_ready = ordy;
    sreg_wr      = swr;
    sreg_din     = sdin;
    cond_sel     = csel;
    @(negedge clk);
    check_outputs();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 3'd0, 3'd0, ordy, 1'b0, 4'h0, 3'd0);
  endtask

  initial begin
    model_reset();
    wb.in_valid = 1'b0; wb.in_result = '0; wb.in_sreg = '0; wb.in_op = '0;
    wb.in_dst = '0; wb.out_ready = 1'b0; sreg_wr = 1'b0; sreg_din = '0; cond_sel = '0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(wb.out_valid), 32'd0);
    chk("rst_in_ready",  32'(wb.in_ready),  32'd1);
    chk("rst_sreg",      32'(sreg_q),       32'd0);
    rst_n = 1'b1;
    idle(1'b1, 2);

    // First result: ADD into empty buffer, visible one cycle later.
    cycle(1'b1, 16'h0000, 4'b0101, 3'd2, 3'd3, 1'b1, 1'b0, 4'h0, 3'd0);
    chk("t1_valid", 32'(wb.out_valid), 32'd1);
    chk("t1_data",  32'(wb.out_data),  32'h0);
    chk("t1_dst",   32'(wb.out_dst),   32'd3);
    chk("t1_sreg",  32'(sreg_q),       32'b0101);
    chk("t1_eq",    32'(cond_true),    32'd1);
    idle(1'b1, 1);

    // Three pushes against a stalled register file: third is dropped.
    cycle(1'b1, 16'hAAAA, 4'h0, 3'd3, 3'd1, 1'b0, 1'b0, 4'h0, 3'd1);
    cycle(1'b1, 16'hBBBB, 4'h0, 3'd4, 3'd2, 1'b0, 1'b0, 4'h0, 3'd1);
    chk("t2_full", 32'(wb.in_ready), 32'd0);
    cycle(1'b1, 16'hCCCC, 4'h0, 3'd5, 3'd4, 1'b0, 1'b0, 4'h0, 3'd1);
    idle(1'b0, 2);
    chk("t2_held", 32'(wb.out_data), 32'hAAAA);
    idle(1'b1, 3);

    // OR keeps C,V and loads Z,N.
    cycle(1'b0, 16'h0, 4'h0, 3'd0, 3'd0, 1'b1, 1'b1, 4'b1100, 3'd6);
    cycle(1'b1, 16'h8000, 4'b0010, 3'd1, 3'd5, 1'b1, 1'b0, 4'h0, 3'd6);
    chk("t3_sreg", 32'(sreg_q), 32'b1110);
    chk("t3_lt",   32'(cond_true), 32'd0);
    cond_sel = 3'd2;
    #1;
    chk("t3_cs",   32'(cond_true), 32'd1);
    idle(1'b1, 2);

    // Steady state at count=1 with simultaneous push and pop.
    cycle(1'b1, 16'd1, 4'h0, 3'd7, 3'd1, 1'b0, 1'b0, 4'h0, 3'd7);
    for (int k = 2; k <= 4; k++)
      cycle(1'b1, 16'(k), 4'h0, 3'd7, 3'(k), 1'b1, 1'b0, 4'h0, 3'd7);
    chk("t4_data", 32'(wb.out_data), 32'd4);
    idle(1'b1, 2);

    // Explicit load wins over SUB flag update; entry still buffered.
    cycle(1'b1, 16'h1234, 4'b0001, 3'd6, 3'd6, 1'b0, 1'b1, 4'b1000, 3'd0);
    chk("t5_sreg",  32'(sreg_q), 32'b1000);
    chk("t5_valid", 32'(wb.out_valid), 32'd1);
    chk("t5_data",  32'(wb.out_data), 32'h1234);
    idle(1'b1, 2);

    // Asynchronous reset with a full buffer.
    cycle(1'b1, 16'h5555, 4'b1111, 3'd2, 3'd1, 1'b0, 1'b0, 4'h0, 3'd0);
    cycle(1'b1, 16'h6666, 4'b1111, 3'd2, 3'd2, 1'b0, 1'b0, 4'h0, 3'd0);
    chk("t6_pre_full", 32'(wb.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(wb.out_valid), 32'd0);
    chk("t6_sreg",  32'(sreg_q),       32'd0);
    chk("t6_ready", 32'(wb.in_ready),  32'd1);
    chk("t6_data",  32'(wb.out_data),  32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    idle(1'b1, 3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
            4'($urandom), 3'($urandom_range(0, 7)));
    end
    idle(1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
